// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, issuer FSM states, command record.
package alu_pkg;

  localparam logic [7:0] OPC_ADD  = 8'h00;
  localparam logic [7:0] OPC_SUB  = 8'h01;
  localparam logic [7:0] OPC_MUL  = 8'h02;
  localparam logic [7:0] OPC_AND  = 8'h03;
  localparam logic [7:0] OPC_OR   = 8'h04;
  localparam logic [7:0] OPC_XOR  = 8'h05;
  localparam logic [7:0] OPC_LAND = 8'h06;
  localparam logic [7:0] OPC_LOR  = 8'h07;
  localparam logic [7:0] OPC_MAX  = 8'h07;

  localparam logic [7:0] TMO_RESULT = 8'hFF;
  localparam int         CMD_W      = 26;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] seld;
  } alu_cmd_t;

  function automatic logic opc_legal(input logic [7:0] opc);
    return opc <= OPC_MAX;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  assign rdata = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: buffers commands, pulses the ALU, returns results in order.
// Optional build macro ALU_CMD_ISSUER_TIMEOUT_EN bounds the wait for alu_done.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_opc,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [1:0] cmd_seld,
  output logic       alu_enable,
  output logic [7:0] alu_opc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_seld,
  input  logic [7:0] alu_z,
  input  logic       alu_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_z,
  output logic [7:0] res_opc,
  output logic       res_err,
  output logic       busy
);

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_t     state, state_nxt;
  alu_cmd_t   head, cmd_r;
  logic       full, empty, push, pop;
  logic [7:0] tmo_cnt;
  logic       tmo_hit;

  assign push = cmd_valid && !full;
  assign pop  = (state == IDLE) && !empty;

  alu_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata ({cmd_opc, cmd_a, cmd_b, cmd_seld}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Counter reads 1 in the issue cycle; constant-folded away when timeout is disabled.
  assign tmo_hit = TMO_EN && (tmo_cnt >= TMO_LIM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = opc_legal(head.opc) ? ISSUE : HOLD;
      ISSUE:   state_nxt = alu_done ? HOLD : WAIT;
      WAIT:    if (alu_done || tmo_hit) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_r   <= '0;
      res_z   <= '0;
      res_opc <= '0;
      res_err <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          cmd_r   <= head;
          tmo_cnt <= 8'd1;
          // Illegal opcodes bypass the ALU and report straight away.
          if (!opc_legal(head.opc)) begin
            res_z   <= '0;
            res_opc <= head.opc;
            res_err <= 1'b1;
          end
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (alu_done) begin
            res_z   <= alu_z;
            res_opc <= cmd_r.opc;
            res_err <= 1'b0;
          end
        end
        WAIT: begin
          if (alu_done) begin
            res_z   <= alu_z;
            res_opc <= cmd_r.opc;
            res_err <= 1'b0;
          end else if (tmo_hit) begin
            res_z   <= TMO_RESULT;
            res_opc <= cmd_r.opc;
            res_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = !full;
  assign alu_enable = (state == ISSUE);
  assign alu_opc    = cmd_r.opc;
  assign alu_a      = cmd_r.a;
  assign alu_b      = cmd_r.b;
  assign alu_seld   = cmd_r.seld;
  assign res_valid  = (state == HOLD);
  assign busy       = !empty || (state != IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomised bench for alu_cmd_issuer with an ALU model and an in-order result scoreboard.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;
`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
  localparam int LAT_MAX  = 2;
  localparam int SLOW_LAT = 2;
`else
  localparam int LAT_MAX  = 6;
  localparam int SLOW_LAT = 5;
`endif

  logic       clock = 1'b0, reset;
  logic       cmd_valid, cmd_ready, alu_enable, alu_done, res_valid, res_ready, res_err, busy;
  logic [7:0] cmd_opc, cmd_a, cmd_b, alu_opc, alu_a, alu_b, alu_z, res_z, res_opc;
  logic [1:0] cmd_seld, alu_seld;
  alu_cmd_t   cmd_in;

  assign {cmd_opc, cmd_a, cmd_b, cmd_seld} = cmd_in;

  always #5 clock = ~clock;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opc(cmd_opc), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_seld(cmd_seld),
    .alu_enable(alu_enable), .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_seld(alu_seld), .alu_z(alu_z), .alu_done(alu_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_opc(res_opc), .res_err(res_err), .busy(busy)
  );

  int       checks = 0, errors = 0;
  alu_cmd_t exp_q[$], iss_q[$];
  alu_cmd_t cur;
  int       pend = 0, lat_cfg = 0, nres = 0, nen = 0;
  bit       spur = 1'b0, tmo_mode = 1'b0, acc = 1'b0;

  function automatic logic [7:0] alu_fn(input alu_cmd_t c);
    case (c.opc)
      OPC_ADD:  return c.a + c.b;
      OPC_SUB:  return c.a - c.b;
      OPC_MUL:  return c.a * c.b;
      OPC_AND:  return c.a & c.b;
      OPC_OR:   return c.a | c.b;
      OPC_XOR:  return c.a ^ c.b;
      OPC_LAND: return {7'b0, (c.a != 8'd0) && (c.b != 8'd0)};
      OPC_LOR:  return {7'b0, (c.a != 8'd0) || (c.b != 8'd0)};
      default:  return 8'h00;
    endcase
  endfunction

  // {err, opc, z} a correct block must return for command c
  function automatic logic [16:0] exp_res(input alu_cmd_t c);
    if (c.opc > OPC_MAX) return {1'b1, c.opc, 8'h00};
    if (tmo_mode)        return {1'b1, c.opc, TMO_RESULT};
    return {1'b0, c.opc, alu_fn(c)};
  endfunction

  function automatic logic [46:0] rst_vec();
    return {cmd_ready, alu_enable, alu_opc, alu_a, alu_b, alu_seld,
            res_valid, res_z, res_opc, res_err, busy};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs set: log the handshakes the next edge takes, then
  // advance one cycle and let the ALU model react to the new state.
  task automatic cyc();
    int lat;
    acc = 1'b0;
    if (cmd_valid && cmd_ready) begin
      exp_q.push_back(cmd_in);
      iss_q.push_back(cmd_in);
      acc = 1'b1;
    end
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("res_extra", 64'(1), 64'(0));
      else begin
        alu_cmd_t e = exp_q.pop_front();
        chk("res", 64'({res_err, res_opc, res_z}), 64'(exp_res(e)));
      end
      nres++;
    end
    if (pend > 0) chk("alu_hold", 64'({alu_opc, alu_a, alu_b, alu_seld}), 64'(cur));
    @(posedge clock);
    @(negedge clock);
    alu_done = 1'b0;
    if (alu_enable) begin
      nen++;
      chk("issue_dup", 64'(pend), 64'(0));
      while (iss_q.size() > 0 && iss_q[0].opc > OPC_MAX) iss_q.delete(0);
      if (iss_q.size() == 0) chk("issue_extra", 64'(1), 64'(0));
      else begin
        cur = iss_q.pop_front();
        chk("issue", 64'({alu_opc, alu_a, alu_b, alu_seld}), 64'(cur));
      end
      lat = (lat_cfg < 0) ? int'($urandom_range(LAT_MAX, 0)) : lat_cfg;
      if (lat == 0) begin
        alu_done = 1'b1;
        alu_z    = alu_fn(cur);
        pend     = 0;
      end else begin
        alu_z = 8'($urandom);
        pend  = lat;
      end
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        alu_done = 1'b1;
        alu_z    = alu_fn(cur);
      end
    end else if (spur && $urandom_range(7, 0) == 0) begin
      alu_done = 1'b1;
      alu_z    = 8'($urandom);
    end
  endtask

  task automatic push(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] seld);
    int n;
    n = 0;
    cmd_in    = '{opc: opc, a: a, b: b, seld: seld};
    cmd_valid = 1'b1;
    do begin
      cyc();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("push_timeout", 64'(0), 64'(1));
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 60) begin
      cyc();
      n++;
    end
    if (!res_valid) chk(tag, 64'(0), 64'(1));
  endtask

  initial begin
    int n, n0;
    cmd_in = '0; cmd_valid = 1'b0; res_ready = 1'b0; alu_done = 1'b0; alu_z = 8'h00;
    reset  = 1'b0;
    #1 chk("reset", 64'(rst_vec()), 64'({1'b1, 46'b0}));
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // single legal command, combinational ALU
    lat_cfg = 0; res_ready = 1'b1;
    cmd_in = '{opc: 8'h01, a: 8'h09, b: 8'h03, seld: 2'b10};
    cmd_valid = 1'b1;
    cyc();
    chk("single_acc", 64'(acc), 64'(1));
    cmd_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 20) begin cyc(); n++; end
    chk("single_lat", 64'(n), 64'(3));
    chk("single_res", 64'({res_err, res_opc, res_z}), 64'({1'b0, 8'h01, 8'h06}));
    cyc();
    chk("single_drop", 64'(res_valid), 64'(0));

    // fill the FIFO behind a stalled result
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(i), 8'($urandom), 8'($urandom), 2'(i));
    chk("full_ready", 64'(cmd_ready), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    repeat (3) cyc();
    chk("full_hold", 64'({cmd_ready, res_valid}), 64'({1'b0, 1'b1}));
    res_ready = 1'b1;
    n0 = nres; n = 0;
    while (exp_q.size() > 0 && n < 100) begin cyc(); n++; end
    chk("fill_count", 64'(nres - n0), 64'(5));

    // illegal opcode never reaches the ALU
    res_ready = 1'b0; n0 = nen;
    push(8'h2A, 8'h11, 8'h22, 2'b01);
    wait_res("illegal_timeout");
    chk("illegal_res", 64'({res_err, res_opc, res_z}), 64'({1'b1, 8'h2A, 8'h00}));
    chk("illegal_en", 64'(nen - n0), 64'(0));
    res_ready = 1'b1;
    cyc();

    // slow ALU; bus stability is checked every cycle while pending
    lat_cfg = SLOW_LAT;
    push(8'h02, 8'h0F, 8'h03, 2'b11);
    wait_res("slow_timeout");
    chk("slow_res", 64'({res_err, res_opc, res_z}), 64'({1'b0, 8'h02, 8'h2D}));
    cyc();

`ifdef ALU_CMD_ISSUER_TIMEOUT_EN
    tmo_mode = 1'b1; lat_cfg = TIMEOUT + 4; res_ready = 1'b0;
    push(8'h00, 8'h01, 8'h02, 2'b00);
    wait_res("tmo_timeout");
    chk("tmo_res", 64'({res_err, res_opc, res_z}), 64'({1'b1, 8'h00, 8'hFF}));
    repeat (8) cyc();
    chk("tmo_late", 64'({res_err, res_opc, res_z}), 64'({1'b1, 8'h00, 8'hFF}));
    res_ready = 1'b1;
    cyc();
    tmo_mode = 1'b0; pend = 0;
`endif

    // reset during WAIT with two commands queued
    lat_cfg = 100; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h00, 8'(i), 8'h01, 2'b00);
    chk("mid_busy", 64'({busy, alu_enable, res_valid}), 64'({1'b1, 1'b0, 1'b0}));
    reset = 1'b0;
    #1 chk("mid_reset", 64'(rst_vec()), 64'({1'b1, 46'b0}));
    exp_q.delete(); iss_q.delete(); pend = 0; alu_done = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n0 = nres;
    repeat (8) cyc();
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_nres", 64'(nres - n0), 64'(0));

    // randomised traffic with spurious done pulses
    lat_cfg = -1; spur = 1'b1; n0 = nres;
    repeat (400) begin
      cmd_valid = 1'($urandom_range(1, 0));
      cmd_in.opc  = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, 8))
                                                 : 8'($urandom_range(7, 0));
      cmd_in.a    = 8'($urandom);
      cmd_in.b    = 8'($urandom);
      cmd_in.seld = 2'($urandom);
      res_ready   = ($urandom_range(9, 0) < 7);
      cyc();
    end
    cmd_valid = 1'b0; res_ready = 1'b1; n = 0;
    while ((exp_q.size() > 0 || busy) && n < 300) begin cyc(); n++; end
    chk("drain_q", 64'(exp_q.size()), 64'(0));
    chk("drain_busy", 64'(busy), 64'(0));
    chk("rand_some", 64'(nres - n0 > 20), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side controller for the 8-bit ALU. It accepts operation commands (opcode, two operands, select) from an upstream valid/ready stream and buffers them in a small FIFO. It issues each command to the ALU with a one-cycle enable pulse, waits for the ALU's `done`, and returns the result on a downstream valid/ready stream. The block sits between the datapath sequencer and the ALU and owns the ALU's `enable`/`opc`/`a`/`b`/`seld` inputs.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, minimum 2.
- `TIMEOUT`, 15: maximum cycles to wait for `alu_done`, counted from the issue cycle; range 1–255.
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_opc` in 8: ALU opcode.
- `cmd_a`, `cmd_b` in 8: operands.
- `cmd_seld` in 2: passed through to the ALU unchanged.
- `alu_enable` out 1: one-cycle issue pulse.
- `alu_opc` out 8, `alu_a` out 8, `alu_b` out 8, `alu_seld` out 2: registered command fields, held stable from ISSUE until the block leaves WAIT.
- `alu_z` in 8: ALU result.
- `alu_done` in 1: ALU completion.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_z` out 8: result.
- `res_opc` out 8: opcode of the result.
- `res_err` out 1: illegal opcode or timeout.
- `busy` out 1: FIFO non-empty or FSM not in IDLE.

## Operation
- Reset values: `cmd_ready`=1, `alu_enable`=0, `alu_*` buses=0, `res_valid`=0, `res_z`=0, `res_opc`=0, `res_err`=0, `busy`=0. FIFO is empty and the FSM is in IDLE.
- FIFO:
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready` = !full.
  - Pointers wrap modulo DEPTH. A push and a pop in the same cycle keep the count unchanged.
  - A push while full is impossible because `cmd_ready` is 0.
- FSM: IDLE → ISSUE → WAIT → HOLD → IDLE.
  - IDLE: if the FIFO is non-empty, pop the head into the `alu_*` registers.
    - Legal opcode (0x00–0x07): go to ISSUE.
    - Opcode above 0x07: never issued. Set `res_z`=0 and `res_err`=1, then go to HOLD.
  - ISSUE: `alu_enable`=1 for exactly this cycle. `alu_done` is sampled here already. If high, capture `alu_z` and go to HOLD; otherwise go to WAIT.
  - WAIT: `alu_enable`=0. On `alu_done`=1, capture `alu_z` into `res_z` with `res_err`=0 and go to HOLD.
  - HOLD: `res_valid`=1, and `res_z`/`res_opc`/`res_err` are stable. On `res_ready`, go to IDLE.
- Ordering: results return in command order, with one command in flight.
- `alu_done` outside ISSUE/WAIT is ignored.

## Timing
- Command accepted in cycle N with the FIFO empty and the FSM in IDLE: pop at N+1, ISSUE at N+2.
- Combinational ALU (`done` in ISSUE): `res_valid` at N+3.
- `res_valid` falls the cycle after the `res_ready` handshake. The next pop can occur in that same IDLE cycle.
- Back-to-back throughput with combinational ALU and `res_ready` tied high: one result per 3 cycles.
- Reset asserted mid-operation:
  - All state clears immediately and asynchronously. Queued commands are discarded.
  - `alu_enable` drops without waiting for `done`.
  - No result is produced for the in-flight command.

## Configuration
- `ALU_CMD_ISSUER_TIMEOUT_EN` defined:
  - WAIT keeps an 8-bit cycle counter that starts at 1 in ISSUE.
  - When the counter reaches TIMEOUT without `alu_done`, set `res_z`=8'hFF and `res_err`=1, then go to HOLD.
  - `alu_done` arriving later is ignored.
- Undefined: no counter; WAIT waits indefinitely for `alu_done`.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OPC_ADD`..`OPC_LOR` (0x00–0x07) and `OPC_MAX`=0x07.
  - FSM state typedef: IDLE, ISSUE, WAIT, HOLD.
  - Timeout result constant 8'hFF.
- One sub-module: `alu_cmd_fifo`, a synchronous FIFO of width 26 (opc 8, a 8, b 8, seld 2) and depth DEPTH, with full/empty flags.

## Test plan
- Single legal command: opc=0x01, a=0x09, b=0x03, ALU `done` in ISSUE → `res_z`=0x06, `res_err`=0, `res_valid` 3 cycles after acceptance.
- Fill FIFO: push 5 commands with `res_ready`=0 → `cmd_ready`=0 after 4 entries are queued and 1 is in flight. Release `res_ready` → all 5 results return in order.
- Illegal opcode 0x2A → `alu_enable` never pulses; result `res_z`=0x00, `res_err`=1, `res_opc`=0x2A.
- Slow ALU with `done` 5 cycles after enable: a=0x0F, b=0x03, opc=0x02 → `res_z`=0x2D. `alu_*` buses are stable throughout WAIT.
- With `ALU_CMD_ISSUER_TIMEOUT_EN` defined and TIMEOUT=4, `done` held low → HOLD with `res_z`=0xFF, `res_err`=1. A late `done` has no effect.
- Reset asserted during WAIT with 2 commands queued → all outputs at reset values the same cycle; after release, `busy`=0 and no results.
